// File: rtl/nco_phase_accumulator.sv
// -----------------------------------------------------------------------------
// nco_phase_accumulator
//
// Phase accumulator that drives the address of a sine lookup table. Every
// enabled cycle it adds the active frequency tuning word (FTW) to the
// accumulator. It also presents the top LUT_DEPTH accumulator bits plus a phase
// offset as a registered table address.
//
// A new FTW is accepted through a valid/ready handshake and held in a pending
// register. It is applied phase-continuously on one of these edges:
//   - an accumulator wrap,
//   - an idle (enable=0) edge,
//   - a phase clear.
//
// Ports
//   clk           in   rising-edge system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   advance accumulator / emit an address this cycle
//   ftw_in        in   [ACC_WIDTH]  offered tuning word
//   ftw_valid     in   ftw_in is offered
//   ftw_ready     out  a new tuning word can be accepted (no word pending)
//   phase_offset  in   [LUT_DEPTH]  unsigned address offset, mod 2^LUT_DEPTH
//   phase_clear   in   synchronous accumulator clear (priority over enable)
//   address       out  [LUT_DEPTH]  registered sine-table address
//   address_valid out  address is a fresh sample
//   wrap          out  one-cycle pulse on accumulator carry-out
//   ftw_active    out  [ACC_WIDTH]  tuning word currently in use
// -----------------------------------------------------------------------------
module nco_phase_accumulator #(
    parameter int ACC_WIDTH = 24,
    parameter int LUT_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] ftw_in,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    input  logic [LUT_DEPTH-1:0] phase_offset,
    input  logic                 phase_clear,
    output logic [LUT_DEPTH-1:0] address,
    output logic                 address_valid,
    output logic                 wrap,
    output logic [ACC_WIDTH-1:0] ftw_active
);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] pend_ftw;
    logic                 pend_flag;

    logic [ACC_WIDTH:0]   acc_sum;
    logic                 carry;
    logic                 capture;
    logic                 apply_pend;
    logic                 pend_flag_nxt;

    // Table address is the accumulator MSBs shifted by the offset.
    // It wraps modulo the table size.
    function automatic logic [LUT_DEPTH-1:0] offset_addr(
        input logic [LUT_DEPTH-1:0] msbs,
        input logic [LUT_DEPTH-1:0] off
    );
        return msbs + off;
    endfunction

    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, ftw_active};
        carry   = acc_sum[ACC_WIDTH];
        // ftw_ready is the registered inverse of pend_flag.
        // So a capture can never coincide with an apply.
        capture = ftw_valid && ftw_ready;

        // Only a word that was already pending before this edge can be applied.
        if (phase_clear) begin
            apply_pend = pend_flag;
        end else if (enable) begin
            apply_pend = pend_flag && carry;
        end else begin
            apply_pend = pend_flag;
        end

        pend_flag_nxt = capture || (pend_flag && !apply_pend);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            ftw_active    <= '0;
            pend_ftw      <= '0;
            pend_flag     <= 1'b0;
            ftw_ready     <= 1'b1;
            address       <= '0;
            address_valid <= 1'b0;
            wrap          <= 1'b0;
        end else begin
            // ---- accumulate / address stage ----
            if (phase_clear) begin
                acc           <= '0;
                wrap          <= 1'b0;
                address_valid <= 1'b0;
            end else if (enable) begin
                // The address uses the pre-increment accumulator.
                // The first sample after a clear is therefore phase_offset.
                address       <= offset_addr(acc[ACC_WIDTH-1 -: LUT_DEPTH], phase_offset);
                address_valid <= 1'b1;
                acc           <= acc_sum[ACC_WIDTH-1:0];
                wrap          <= carry;
            end else begin
                address_valid <= 1'b0;
                wrap          <= 1'b0;
            end

            // ---- tuning word handshake / apply ----
            // On an apply edge the addition above still uses the old word.
            if (apply_pend) begin
                ftw_active <= pend_ftw;
            end
            if (capture) begin
                pend_ftw <= ftw_in;
            end
            pend_flag <= pend_flag_nxt;
            ftw_ready <= !pend_flag_nxt;
        end
    end

endmodule

// File: tb/tb_nco_phase_accumulator.sv
module tb_nco_phase_accumulator;

    localparam int ACC = 24;
    localparam int LUT = 8;
    localparam longint ACC_MOD = 64'd1 << ACC;
    localparam longint LUT_MOD = 64'd1 << LUT;
    localparam int SH = ACC - LUT;

    logic           clk;
    logic           rst_n;
    logic           enable;
    logic [ACC-1:0] ftw_in;
    logic           ftw_valid;
    logic           ftw_ready;
    logic [LUT-1:0] phase_offset;
    logic           phase_clear;
    logic [LUT-1:0] address;
    logic           address_valid;
    logic           wrap;
    logic [ACC-1:0] ftw_active;

    nco_phase_accumulator #(.ACC_WIDTH(ACC), .LUT_DEPTH(LUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .ftw_in       (ftw_in),
        .ftw_valid    (ftw_valid),
        .ftw_ready    (ftw_ready),
        .phase_offset (phase_offset),
        .phase_clear  (phase_clear),
        .address      (address),
        .address_valid(address_valid),
        .wrap         (wrap),
        .ftw_active   (ftw_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: integer phase, tuning word and a one-deep mailbox.
    longint m_acc   = 0;
    longint m_ftw   = 0;
    longint m_pend  = 0;
    bit     m_pflag = 0;
    bit     m_ready = 1;
    longint m_addr  = 0;
    bit     m_av    = 0;
    bit     m_wrap  = 0;

    task automatic model_reset();
        m_acc = 0; m_ftw = 0; m_pend = 0; m_pflag = 0; m_ready = 1;
        m_addr = 0; m_av = 0; m_wrap = 0;
    endtask

    task automatic model_step();
        bit     took;
        bit     use_pending;
        longint sum;
        took = ftw_valid && m_ready;
        use_pending = 0;
        if (phase_clear) begin
            m_acc = 0; m_wrap = 0; m_av = 0;
            use_pending = m_pflag;
        end else if (enable) begin
            m_addr = ((m_acc / (64'd1 << SH)) + longint'(phase_offset)) % LUT_MOD;
            m_av = 1;
            sum = m_acc + m_ftw;
            m_wrap = (sum >= ACC_MOD);
            m_acc = sum % ACC_MOD;
            use_pending = m_pflag && m_wrap;
        end else begin
            m_av = 0; m_wrap = 0;
            use_pending = m_pflag;
        end
        if (use_pending) begin
            m_ftw = m_pend;
            m_pflag = 0;
        end
        if (took) begin
            m_pend = longint'(ftw_in);
            m_pflag = 1;
        end
        m_ready = !m_pflag;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("model_address", longint'(address), m_addr);
        chk("model_address_valid", longint'(address_valid), longint'(m_av));
        chk("model_wrap", longint'(wrap), longint'(m_wrap));
        chk("model_ftw_ready", longint'(ftw_ready), longint'(m_ready));
        chk("model_ftw_active", longint'(ftw_active), m_ftw);
    endtask

    // Inputs change at the falling edge; outputs are compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_address"}, longint'(address), 0);
        chk({tag, "_address_valid"}, longint'(address_valid), 0);
        chk({tag, "_wrap"}, longint'(wrap), 0);
        chk({tag, "_ftw_ready"}, longint'(ftw_ready), 1);
        chk({tag, "_ftw_active"}, longint'(ftw_active), 0);
    endtask

    // Reset asserted and released between two rising edges.
    task automatic async_reset_pulse(input string tag);
        #1 rst_n = 1'b0;
        #1 check_reset_values(tag);
        #1 rst_n = 1'b1;
    endtask

    int wraps;
    int exp_addr[4];
    int exp_wrap[4];

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        ftw_in = '0;
        ftw_valid = 1'b0;
        phase_offset = '0;
        phase_clear = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Load 0x010000 while idle.
        ftw_valid = 1'b1; ftw_in = 24'h010000;
        tick();
        chk("load_ready_low", longint'(ftw_ready), 0);
        ftw_valid = 1'b0;
        tick();
        chk("load_ftw_active", longint'(ftw_active), 64'h010000);

        // Ramp 0..255,0..: one wrap in 260 samples, on the 256th.
        enable = 1'b1;
        wraps = 0;
        for (int i = 0; i < 260; i++) begin
            tick();
            chk("ramp_addr", longint'(address), longint'(i % 256));
            if (wrap) begin
                wraps++;
                chk("ramp_wrap_pos", longint'(i), 255);
            end
        end
        chk("ramp_wrap_count", longint'(wraps), 1);

        // The offset shifts the next address only; the step is unchanged.
        phase_offset = 8'd64;
        tick();
        chk("offset64_addr", longint'(address), 68);
        phase_offset = 8'd0;
        tick();
        chk("offset0_addr", longint'(address), 5);

        // A clear with a pending word applies it; the sequence restarts 0,4,8.
        ftw_valid = 1'b1; ftw_in = 24'h040000;
        tick();
        chk("pend_ready_low", longint'(ftw_ready), 0);
        ftw_valid = 1'b0; phase_clear = 1'b1;
        tick();
        chk("clear_ftw_active", longint'(ftw_active), 64'h040000);
        chk("clear_av", longint'(address_valid), 0);
        phase_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clear_seq_addr", longint'(address), longint'(4 * i));
        end

        // Half-scale word: 0,128,0,128 with a wrap every second sample.
        enable = 1'b0; ftw_valid = 1'b1; ftw_in = 24'h800000;
        tick();
        ftw_valid = 1'b0; phase_clear = 1'b1;
        tick();
        phase_clear = 1'b0; enable = 1'b1;
        exp_addr = '{0, 128, 0, 128};
        exp_wrap = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("half_addr", longint'(address), longint'(exp_addr[i]));
            chk("half_wrap", longint'(wrap), longint'(exp_wrap[i]));
        end

        // Randomised run against the model.
        for (int n = 0; n < 3000; n++) begin
            enable = ($urandom_range(0, 9) != 0);
            phase_clear = ($urandom_range(0, 99) == 0);
            ftw_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) ftw_in = '0;
            else ftw_in = ACC'($urandom >> (8 + $urandom_range(0, 6)));
            if ($urandom_range(0, 19) == 0) phase_offset = LUT'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset_pulse("rand_reset");
            tick();
        end

        // Mid-run reset with a pending word discards it.
        enable = 1'b1; phase_clear = 1'b0;
        ftw_valid = (ftw_ready == 1'b1);
        ftw_in = 24'h123456;
        tick();
        ftw_valid = 1'b0;
        tick();
        async_reset_pulse("midrun_reset");
        enable = 1'b0;
        tick();
        chk("post_reset_ftw_active", longint'(ftw_active), 0);
        chk("post_reset_ready", longint'(ftw_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
